// File: rtl/pc_unit_if.sv
// Connection bundle between the controller/fetch side and the PC stage.
// en is the only flow control: with en=0 the stage holds everything; there is no ready back-pressure.
interface pc_unit_if;
  logic        en;
  logic [1:0]  npc_sel;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_value;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic [31:0] err_target;
  logic [31:0] instr_count;
  logic        fsm_state;   // debug view of the FSM: 0 = RUN, 1 = HALT

  modport master (
    output en, npc_sel, branch_taken, imm16, instr_index, rs_value,
    input  pc, pc_plus4, halted, err_target, instr_count, fsm_state
  );

  modport slave (
    input  en, npc_sel, branch_taken, imm16, instr_index, rs_value,
    output pc, pc_plus4, halted, err_target, instr_count, fsm_state
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter and next-PC selection with an instruction-memory window check
// that freezes the PC in a sticky HALT state on an illegal target.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  localparam logic [31:0] WIN_LO = RESET_PC;
  localparam logic [31:0] WIN_HI = RESET_PC + (32'(IM_WORDS) << 2) - 32'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] cnt_q, cnt_next;
  logic [31:0] err_q, err_next;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] npc;
  logic        npc_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      pc_q  <= RESET_PC;
      cnt_q <= 32'd0;
      err_q <= 32'd0;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      cnt_q <= cnt_next;
      err_q <= err_next;
    end
  end

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    npc      = pc_plus4;
    case (bus.npc_sel)
      2'b00:   npc = pc_plus4;
      2'b01:   npc = bus.branch_taken ? (pc_plus4 + br_off) : pc_plus4;
      2'b10:   npc = {pc_plus4[31:28], bus.instr_index, 2'b00};
      default: npc = bus.rs_value;
    endcase
    // Unsigned compare on the wrapped value, so a branch past 2^32 lands low and fails.
    npc_legal = (npc[1:0] == 2'b00) && (npc >= WIN_LO) && (npc <= WIN_HI);

    state_next = state;
    pc_next    = pc_q;
    cnt_next   = cnt_q;
    err_next   = err_q;
    case (state)
      ST_RUN: begin
        if (bus.en) begin
          if (npc_legal) begin
            pc_next  = npc;
            cnt_next = cnt_q + 32'd1;
          end else begin
            err_next   = npc;
            state_next = ST_HALT;
          end
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.halted      = (state == ST_HALT);
  assign bus.err_target  = err_q;
  assign bus.instr_count = cnt_q;
  assign bus.fsm_state   = state;

endmodule
